// File: rtl/fetch_inst_buffer_pkg.sv
// Shared frontend/backend types and sizing constants for the instruction buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_inst_buffer_pkg;

    localparam int FETCH_LANES   = 4;
    localparam int DECODE_LANES  = 4;
    localparam int INSTBUF_DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetchEntry_t;

endpackage

// File: rtl/fetch_inst_buffer_compactor.sv
// Maps sparse fetch-lane valids to dense write offsets and an enqueue count.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the offsets are used.
module fetch_inst_buffer_compactor #(
    parameter int FETCH_WIDTH = 4
) (
    input  logic [FETCH_WIDTH-1:0]                              inst_vld,
    output logic [FETCH_WIDTH-1:0][$clog2(FETCH_WIDTH+1)-1:0]   wr_off,
    output logic [$clog2(FETCH_WIDTH+1)-1:0]                    enq_cnt
);
    localparam int CW = $clog2(FETCH_WIDTH + 1);

    logic [CW-1:0] acc;

    // Exclusive prefix sum of the valid bits: each lane's slot offset from tail.
    always_comb begin
        acc = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            wr_off[i] = acc;
            acc       = acc + CW'(inst_vld[i]);
        end
        enq_cnt = acc;
    end

endmodule

// File: rtl/fetch_inst_buffer.sv
// In-order fetch->decode queue: compacts sparse fetch groups, presents oldest entries.
// Latency: one cycle minimum from enqueue to presentation (no bypass).
// Backpressure: o_stall from registered count only; backend consumes all presented lanes or none.
module fetch_inst_buffer
    import fetch_inst_buffer_pkg::*;
#(
    parameter int DEPTH        = INSTBUF_DEPTH,
    parameter int FETCH_WIDTH  = FETCH_LANES,
    parameter int DECODE_WIDTH = DECODE_LANES
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_squash_vld,
    input  logic        [FETCH_WIDTH-1:0]       i_inst_vld,
    input  fetchEntry_t [FETCH_WIDTH-1:0]       i_inst,
    output logic                                o_stall,
    input  logic                                i_backend_stall,
    output logic        [DECODE_WIDTH-1:0]      o_inst_vld,
    output fetchEntry_t [DECODE_WIDTH-1:0]      o_inst
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(FETCH_WIDTH + 1);

    // Stalling at this occupancy guarantees a full fetch group always fits.
    localparam logic [PW-1:0] STALL_TH = PW'(DEPTH - FETCH_WIDTH);
    localparam logic [PW-1:0] DEQ_MAX  = PW'(DECODE_WIDTH);

    // Pointers carry a wrap bit above the index so full and empty are distinguishable.
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] count;
    logic [PW-1:0] deq_cnt;

    fetchEntry_t mem [DEPTH];

    logic [FETCH_WIDTH-1:0][CW-1:0]  wr_off;
    logic [CW-1:0]                   enq_cnt;
    logic [FETCH_WIDTH-1:0][AW-1:0]  wr_addr;
    logic [DECODE_WIDTH-1:0][AW-1:0] rd_addr;
    logic                            enq_en;
    logic                            deq_en;

    fetch_inst_buffer_compactor #(
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_compactor (
        .inst_vld (i_inst_vld),
        .wr_off   (wr_off),
        .enq_cnt  (enq_cnt)
    );

    assign count   = tail - head;
    assign o_stall = count > STALL_TH;
    assign enq_en  = !o_stall && !i_squash_vld;
    assign deq_en  = !i_backend_stall && !i_squash_vld;
    assign deq_cnt = (count < DEQ_MAX) ? count : DEQ_MAX;

    // Slot addresses for valid lanes, wrapping naturally at the index width.
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            wr_addr[i] = tail[AW-1:0] + AW'(wr_off[i]);
        end
    end

    // Storage write: only valid lanes land, packed densely from tail.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (enq_en && i_inst_vld[i]) begin
                mem[wr_addr[i]] <= i_inst[i];
            end
        end
    end

    // Pointer update: squash wins over both enqueue and dequeue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
        end else if (i_squash_vld) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq_en) begin
                tail <= tail + PW'(enq_cnt);
            end
            if (deq_en) begin
                head <= head + deq_cnt;
            end
        end
    end

    // Output window: oldest entries from head, valid lanes contiguous from lane 0.
    always_comb begin
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            rd_addr[k]    = head[AW-1:0] + AW'(k);
            o_inst[k]     = mem[rd_addr[k]];
            o_inst_vld[k] = (PW'(k) < count) && !i_squash_vld;
        end
    end

endmodule
